// File: rtl/exp4_unidade_controle_if.sv
// Handshake/status bundle between the experiment-4 control unit and its datapath.
// The control unit uses the slave modport; the datapath (or a bench) uses master.
interface exp4_unidade_controle_if;
    logic       iniciar;
    logic       jogada;
    logic       igual;
    logic       fimC;
    logic       zeraC;
    logic       contaC;
    logic       zeraR;
    logic       registraR;
    logic       pronto;
    logic       acertou;
    logic       errou;
    logic       timeout;
    logic [3:0] db_estado;

    modport master (
        output iniciar, jogada, igual, fimC,
        input  zeraC, contaC, zeraR, registraR, pronto, acertou, errou, timeout, db_estado
    );

    modport slave (
        input  iniciar, jogada, igual, fimC,
        output zeraC, contaC, zeraR, registraR, pronto, acertou, errou, timeout, db_estado
    );
endinterface

// File: rtl/exp4_unidade_controle.sv
// Moore control unit for the experiment-4 datapath: one address per move, ends in hit/miss.
// Optional round timeout in espera is enabled by defining UC_TIMEOUT_EN.
module exp4_unidade_controle #(
    parameter int unsigned TIMEOUT_CYCLES = 3000
) (
    input logic                    clock,
    input logic                    reset,
    exp4_unidade_controle_if.slave uc
);

    typedef enum logic [3:0] {
        inicial     = 4'b0000,
        preparacao  = 4'b0001,
        espera      = 4'b0010,
        registra    = 4'b0100,
        comparacao  = 4'b0101,
        proximo     = 4'b0110,
`ifdef UC_TIMEOUT_EN
        fim_timeout = 4'b1101,
`endif
        fim_acertou = 4'b1010,
        fim_errou   = 4'b1110
    } estado_t;

    estado_t state, next_state;
    logic    jogada_d;
    logic    pulse;

    // jogada_d resets to 1 so a key held through reset never counts as a move
    always_ff @(posedge clock) begin
        if (reset) begin
            state    <= inicial;
            jogada_d <= 1'b1;
        end else begin
            state    <= next_state;
            jogada_d <= uc.jogada;
        end
    end

    assign pulse = uc.jogada & ~jogada_d;

`ifdef UC_TIMEOUT_EN
    logic [15:0] cnt;
    logic        expired;

    always_ff @(posedge clock) begin
        if (reset || state != espera)
            cnt <= '0;
        else
            cnt <= cnt + 16'd1;
    end

    assign expired = (cnt == 16'(TIMEOUT_CYCLES - 1));
`else
    // Without the timeout feature the parameter has no effect.
    if (TIMEOUT_CYCLES == 0) begin : g_timeout_unused
    end
`endif

    always_comb begin
        next_state = state;
        case (state)
            inicial:     if (uc.iniciar) next_state = preparacao;
            preparacao:  next_state = espera;
            espera: begin
                if (pulse)
                    next_state = registra;
`ifdef UC_TIMEOUT_EN
                else if (expired)
                    next_state = fim_timeout;
`endif
            end
            registra:    next_state = comparacao;
            // a mismatch outranks the last-address flag
            comparacao: begin
                if (!uc.igual)
                    next_state = fim_errou;
                else if (uc.fimC)
                    next_state = fim_acertou;
                else
                    next_state = proximo;
            end
            proximo:     next_state = espera;
            fim_acertou: if (uc.iniciar) next_state = preparacao;
            fim_errou:   if (uc.iniciar) next_state = preparacao;
`ifdef UC_TIMEOUT_EN
            fim_timeout: if (uc.iniciar) next_state = preparacao;
`endif
            default:     next_state = inicial;
        endcase
    end

    always_comb begin
        uc.zeraC     = 1'b0;
        uc.zeraR     = 1'b0;
        uc.registraR = 1'b0;
        uc.contaC    = 1'b0;
        uc.pronto    = 1'b0;
        uc.acertou   = 1'b0;
        uc.errou     = 1'b0;
        uc.timeout   = 1'b0;
        case (state)
            preparacao: begin
                uc.zeraC = 1'b1;
                uc.zeraR = 1'b1;
            end
            registra:    uc.registraR = 1'b1;
            proximo:     uc.contaC    = 1'b1;
            fim_acertou: begin
                uc.pronto  = 1'b1;
                uc.acertou = 1'b1;
            end
            fim_errou: begin
                uc.pronto = 1'b1;
                uc.errou  = 1'b1;
            end
`ifdef UC_TIMEOUT_EN
            fim_timeout: begin
                uc.pronto  = 1'b1;
                uc.errou   = 1'b1;
                uc.timeout = 1'b1;
            end
`endif
            default: ;
        endcase
    end

    assign uc.db_estado = state;

endmodule

// File: tb/tb_exp4_unidade_controle.sv
// Directed self-checking bench for exp4_unidade_controle (timeout cases need UC_TIMEOUT_EN).
module tb_exp4_unidade_controle;

    logic clock = 1'b0;
    logic reset = 1'b1;
    int   checks = 0;
    int   errors = 0;
    int   n_registra = 0;
    int   n_conta = 0;

    exp4_unidade_controle_if uc_if ();

    exp4_unidade_controle #(.TIMEOUT_CYCLES(10)) dut (
        .clock(clock),
        .reset(reset),
        .uc   (uc_if.slave)
    );

    always #5 clock = ~clock;

    always @(negedge clock) begin
        if (uc_if.registraR === 1'b1) n_registra++;
        if (uc_if.contaC === 1'b1) n_conta++;
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic expect_state(input string name, input logic [3:0] exp);
        checks++;
        if (uc_if.db_estado !== exp) begin
            errors++;
            $display("FAIL %s: db_estado=%b expected=%b", name, uc_if.db_estado, exp);
        end
    endtask

    // outputs packed as {zeraC,zeraR,registraR,contaC,pronto,acertou,errou,timeout}
    task automatic expect_outs(input string name, input logic [7:0] exp);
        logic [7:0] got;
        got = {uc_if.zeraC, uc_if.zeraR, uc_if.registraR, uc_if.contaC,
               uc_if.pronto, uc_if.acertou, uc_if.errou, uc_if.timeout};
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: outs=%b expected=%b", name, got, exp);
        end
    endtask

    task automatic start_round();
        uc_if.iniciar = 1'b1;
        tick();
        uc_if.iniciar = 1'b0;
        tick();
    endtask

    // one move from espera; returns the state seen three cycles after the pulse
    task automatic do_move(input logic ig, input logic fc, input bit check_timing,
                           output logic [3:0] result);
        uc_if.jogada = 1'b1;
        uc_if.igual  = ig;
        uc_if.fimC   = fc;
        tick();
        if (check_timing) begin
            expect_state("move_registra", 4'b0100);
            expect_outs("move_registraR", 8'b0010_0000);
        end
        uc_if.jogada = 1'b0;
        tick();
        if (check_timing) expect_state("move_comparacao", 4'b0101);
        tick();
        result = uc_if.db_estado;
        if (result == 4'b0110) tick();
    endtask

    task automatic test_reset();
        uc_if.iniciar = 1'b0;
        uc_if.jogada  = 1'b0;
        uc_if.igual   = 1'b1;
        uc_if.fimC    = 1'b0;
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        tick();
        tick();
        tick();
        expect_state("reset_idle", 4'b0000);
        expect_outs("reset_outs", 8'b0000_0000);
        uc_if.iniciar = 1'b1;
        tick();
        uc_if.iniciar = 1'b0;
        expect_state("start_prep", 4'b0001);
        expect_outs("start_prep_outs", 8'b1100_0000);
        tick();
        expect_state("start_espera", 4'b0010);
        expect_outs("espera_outs", 8'b0000_0000);
    endtask

    task automatic test_held_key();
        n_registra = 0;
        n_conta = 0;
        uc_if.igual  = 1'b1;
        uc_if.fimC   = 1'b0;
        uc_if.jogada = 1'b1;
        for (int i = 0; i < 5; i++) tick();
        expect_state("held_back_espera", 4'b0010);
        for (int i = 0; i < 3; i++) tick();
        uc_if.jogada = 1'b0;
        tick();
        expect_state("held_still_espera", 4'b0010);
        checks++;
        if (n_registra !== 1) begin
            errors++;
            $display("FAIL held_registraR: count=%0d expected=1", n_registra);
        end
        checks++;
        if (n_conta !== 1) begin
            errors++;
            $display("FAIL held_contaC: count=%0d expected=1", n_conta);
        end
    endtask

    task automatic test_acerto();
        logic [3:0] r;
        start_round();
        n_conta = 0;
        for (int i = 0; i < 16; i++) begin
            do_move(1'b1, (i == 15), (i == 0), r);
            if (i < 15) begin
                checks++;
                if (r !== 4'b0110) begin
                    errors++;
                    $display("FAIL acerto_loop: move %0d state=%b expected=0110", i, r);
                end
            end
        end
        expect_state("acerto_final", 4'b1010);
        expect_outs("acerto_outs", 8'b0000_1100);
        checks++;
        if (n_conta !== 15) begin
            errors++;
            $display("FAIL acerto_contaC: count=%0d expected=15", n_conta);
        end
    endtask

    task automatic test_erro();
        logic [3:0] r;
        uc_if.iniciar = 1'b1;
        tick();
        uc_if.iniciar = 1'b0;
        expect_state("restart_prep", 4'b0001);
        expect_outs("restart_pronto_drop", 8'b1100_0000);
        tick();
        do_move(1'b1, 1'b0, 1'b0, r);
        do_move(1'b1, 1'b0, 1'b0, r);
        do_move(1'b0, 1'b0, 1'b1, r);
        expect_state("erro_final", 4'b1110);
        expect_outs("erro_outs", 8'b0000_1010);
        uc_if.iniciar = 1'b1;
        tick();
        uc_if.iniciar = 1'b0;
        expect_state("erro_restart_prep", 4'b0001);
        tick();
        expect_state("erro_restart_espera", 4'b0010);
        // mismatch on the last address still counts as a miss
        do_move(1'b0, 1'b1, 1'b0, r);
        expect_state("erro_priority", 4'b1110);
    endtask

    task automatic test_back_to_back();
        logic [3:0] r;
        start_round();
        n_registra = 0;
        // re-press during comparacao is discarded, and holding it gives no new move
        uc_if.igual  = 1'b1;
        uc_if.fimC   = 1'b0;
        uc_if.jogada = 1'b1;
        tick();
        uc_if.jogada = 1'b0;
        tick();
        uc_if.jogada = 1'b1;
        tick();
        expect_state("b2b_proximo", 4'b0110);
        expect_outs("b2b_contaC", 8'b0001_0000);
        tick();
        tick();
        tick();
        expect_state("b2b_no_queue", 4'b0010);
        checks++;
        if (n_registra !== 1) begin
            errors++;
            $display("FAIL b2b_registraR: count=%0d expected=1", n_registra);
        end
        uc_if.jogada = 1'b0;
        tick();
        do_move(1'b1, 1'b0, 1'b0, r);
        expect_state("b2b_second_move", 4'b0010);
    endtask

    task automatic test_timeout();
`ifdef UC_TIMEOUT_EN
        logic [3:0] r;
        uc_if.jogada = 1'b0;
        start_round();
        for (int i = 0; i < 9; i++) tick();
        expect_state("to_before", 4'b0010);
        tick();
        expect_state("to_fim", 4'b1101);
        expect_outs("to_outs", 8'b0000_1011);
        start_round();
        for (int i = 0; i < 9; i++) tick();
        uc_if.jogada = 1'b1;
        uc_if.igual  = 1'b1;
        uc_if.fimC   = 1'b0;
        tick();
        uc_if.jogada = 1'b0;
        expect_state("to_move_wins", 4'b0100);
        tick();
        tick();
        tick();
        expect_state("to_after_move", 4'b0010);
`else
        uc_if.jogada = 1'b0;
        for (int i = 0; i < 20; i++) tick();
        expect_state("no_to_wait", 4'b0010);
        expect_outs("no_to_outs", 8'b0000_0000);
`endif
    endtask

    task automatic test_reset_mid_round();
        n_registra = 0;
        uc_if.igual  = 1'b1;
        uc_if.fimC   = 1'b0;
        uc_if.jogada = 1'b1;
        tick();
        tick();
        expect_state("mid_comparacao", 4'b0101);
        n_registra = 0;
        reset = 1'b1;
        uc_if.iniciar = 1'b1;
        tick();
        expect_state("mid_reset", 4'b0000);
        expect_outs("mid_reset_outs", 8'b0000_0000);
        tick();
        expect_state("reset_over_iniciar", 4'b0000);
        reset = 1'b0;
        uc_if.iniciar = 1'b0;
        tick();
        start_round();
        for (int i = 0; i < 4; i++) tick();
        expect_state("held_through_reset", 4'b0010);
        checks++;
        if (n_registra !== 0) begin
            errors++;
            $display("FAIL held_through_reset_registraR: count=%0d expected=0", n_registra);
        end
        uc_if.jogada = 1'b0;
    endtask

    initial begin
        test_reset();
        test_held_key();
        test_acerto();
        test_erro();
        test_back_to_back();
        test_timeout();
        test_reset_mid_round();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/exp4_unidade_controle.md
# exp4_unidade_controle

Control unit (Moore FSM) that sequences the experiment-4 datapath: it drives the datapath's counter and register controls (`zeraC`, `contaC`, `zeraR`, `registraR`) and consumes its status flags (`chavesIgualMemoria` as `igual`, `fimC`). It walks the memory one address per player move, compares each registered key pattern with memory, and ends in a hit or a miss. It sits directly upstream of `exp3_fluxo_dados` in the top level and also exposes its state for the 7-segment debug display.

## Interface
- `TIMEOUT_CYCLES`, 3000: clocks allowed in `espera` before a timeout. Used only with `TIMEOUT_EN`.
- `clock`  in  1  system clock; all state changes on the rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `iniciar`  in  1  start request, level-sampled.
- `jogada`  in  1  "any key pressed" (OR of `chaves`), level-sampled; rising edge detected internally.
- `igual`  in  1  from datapath `chavesIgualMemoria`.
- `fimC`  in  1  from datapath; address counter at last position (15).
- `zeraC`  out  1  clear address counter.
- `contaC`  out  1  increment address counter.
- `zeraR`  out  1  clear key register.
- `registraR`  out  1  load key register.
- `pronto`  out  1  round finished.
- `acertou`  out  1  round ended with all 16 matches.
- `errou`  out  1  round ended with a mismatch or timeout.
- `timeout`  out  1  round ended by timeout. Constant 0 without `TIMEOUT_EN`.
- `db_estado`  out  4  current state code.

## Operation
- Reset state: `inicial`. `jogada_d` loads 1, so a key held through reset is not taken as a move. Timeout counter loads 0.
- State codes and transitions (`db_estado`):
  - `inicial` 0000: `iniciar`=1 -> `preparacao`.
  - `preparacao` 0001: always -> `espera`.
  - `espera` 0010: move pulse -> `registra`; else timeout (see Configuration); else stay.
  - `registra` 0100: always -> `comparacao`.
  - `comparacao` 0101: `igual`=0 -> `fim_errou`; else `fimC`=1 -> `fim_acertou`; else -> `proximo`.
  - `proximo` 0110: always -> `espera`.
  - `fim_acertou` 1010: `iniciar`=1 -> `preparacao`.
  - `fim_errou` 1110: `iniciar`=1 -> `preparacao`.
  - `fim_timeout` 1101 (`TIMEOUT_EN` only): `iniciar`=1 -> `preparacao`.
  - Unused codes -> `inicial`.
- Outputs are decoded from state only (Moore):
  - `zeraC`=`zeraR`=1 in `preparacao`.
  - `registraR`=1 in `registra`.
  - `contaC`=1 in `proximo`.
  - `pronto`=1 in all three `fim_*` states.
  - `acertou`=1 in `fim_acertou`.
  - `errou`=1 in `fim_errou` and `fim_timeout`.
  - `timeout`=1 in `fim_timeout`.
  - All outputs are 0 in every other state.
- Move detector: `jogada_d` <= `jogada` every cycle; pulse = `jogada & ~jogada_d`.
  - A held key yields exactly one pulse.
  - Pulses outside `espera` are discarded (not queued).
- Mismatch has priority over `fimC` in `comparacao`.

## Timing
- Move pulse high in cycle N while in `espera` gives: `registra` in N+1 (`registraR` high one cycle), `comparacao` in N+2, `proximo` or `fim_*` in N+3.
- `comparacao` samples `igual` one cycle after `registraR`, so the register output has settled.
- Per-address loop with no waiting is 4 cycles (`espera`, `registra`, `comparacao`, `proximo`).
- `reset`=1 at any rising edge, mid-round included, returns to `inicial`; all outputs are 0 from the next cycle. `reset` overrides `iniciar`.
- Asserting `iniciar` in a `fim_*` state restarts with a fresh `preparacao`; `pronto` drops the following cycle.

## Configuration
- `UC_TIMEOUT_EN` defined:
  - A 16-bit counter clears in every state except `espera` and increments each cycle spent in `espera`.
  - When the counter equals `TIMEOUT_CYCLES-1` and no move pulse is present, the next state is `fim_timeout`.
  - A move pulse in that same cycle wins and goes to `registra`.
- `UC_TIMEOUT_EN` undefined:
  - No counter and no `fim_timeout` state.
  - `timeout` is tied to 0; `espera` waits indefinitely.
  - `TIMEOUT_CYCLES` is ignored.

## Test plan
- Reset, then idle 3 cycles -> `db_estado`=0000, all outputs 0; `iniciar` pulse -> one cycle `db_estado`=0001 with `zeraC`=`zeraR`=1, then 0010.
- In `espera`, hold `jogada`=1 for 5 cycles with `igual`=1, `fimC`=0 -> exactly one `registraR` pulse, one `contaC` pulse, back to 0010; further held cycles produce no activity.
- Sixteen moves with `igual`=1 and `fimC`=1 at the 16th comparison -> `db_estado`=1010, `pronto`=`acertou`=1, `errou`=0; 15 `contaC` pulses total.
- Third move with `igual`=0 -> `db_estado`=1110, `pronto`=`errou`=1; then `iniciar` -> 0001, then 0010.
- With `UC_TIMEOUT_EN` and `TIMEOUT_CYCLES`=10, no move -> `fim_timeout` (1101) exactly 10 cycles after entering `espera`; `timeout`=`errou`=1. A move in cycle 10 instead gives `registra`.
- `reset` asserted while in `comparacao` -> `inicial` on the next edge; `jogada` held through reset gives no move pulse.
